// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM: sequences a shared-ALU datapath over one memory port,
// stalls on mem_ready, counts retired instructions and traps on unsupported encodings.
module riscv_mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Instr,
    input  logic             Zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StJalr, StJal, StBranch, StLui, StAuipc, StTrap
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd  = 4'b0000;
    localparam logic [3:0] AluSub  = 4'b0001;
    localparam logic [3:0] AluAnd  = 4'b0010;
    localparam logic [3:0] AluOr   = 4'b0011;
    localparam logic [3:0] AluXor  = 4'b0100;
    localparam logic [3:0] AluSlt  = 4'b0101;
    localparam logic [3:0] AluSltu = 4'b0110;
    localparam logic [3:0] AluSll  = 4'b0111;
    localparam logic [3:0] AluSrl  = 4'b1000;
    localparam logic [3:0] AluSra  = 4'b1001;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             br_taken, br_bad, retire;
    logic             unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        br_taken = 1'b0;
        br_bad   = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = ~ltu;
            default: br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = (funct3 == 3'b000) ? StJalr : StTrap;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = Instr[5] ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJalr:     state_d = StJal;
            StJal:      state_d = StAluWb;
            StBranch:   state_d = br_bad ? StTrap : StFetch;
            StLui:      state_d = StAluWb;
            StAuipc:    state_d = StAluWb;
            default:    state_d = StTrap;
        endcase
    end

    // Only the final step of each instruction class lands in FETCH; TRAP never leaves.
    assign retire = (state_d == StFetch) &&
                    (state_q inside {StMemWb, StMemWrite, StAluWb, StBranch});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
    assign illegal = (state_q == StTrap);

    always_comb begin
        case (opcode)
            OpStore:        ImmSrc = 3'b001;
            OpBranch:       ImmSrc = 3'b010;
            OpJal:          ImmSrc = 3'b011;
            OpLui, OpAuipc: ImmSrc = 3'b100;
            default:        ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = AluAdd;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            StMemAdr, StJalr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, Instr[30]);
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // Bit 30 is immediate data except for srai.
                ALUControl = alu_dec(funct3, Instr[30] & (funct3 == 3'b101));
            end
            StAluWb:    RegWrite = 1'b1;
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = 2'b10;
                ALUControl = AluSub;
                PCWrite    = br_taken;
            end
            StLui: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            StAuipc: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
        if (reset) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: per-cycle expected outputs are queued
// with the stimulus and compared as the FSM steps through each instruction.
module tb_riscv_mc_controller;

    localparam int unsigned CW = 3;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, SRA = 4'b1001;

    logic          clk, reset, Zero, lt, ltu, mem_ready;
    logic [31:0]   Instr;
    logic          mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]    ImmSrc;
    logic [3:0]    ALUControl;
    logic [CW-1:0] instret;

    riscv_mc_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .lt(lt), .ltu(ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal(illegal), .instret(instret)
    );

    typedef enum {
        SReset, SFetch, SDecode, SMemAdr, SMemRead, SMemWb, SMemWrite, SExecR, SExecI,
        SAluWb, SJalr, SJal, SBranch, SLui, SAuipc, STrap
    } bst_e;

    typedef struct packed {
        logic       mreq, adr, mw, irw, pcw, rw;
        logic [1:0] rs, a, b;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       ill;
    } sig_t;

    typedef struct {
        string tag;
        sig_t  v;
        sig_t  m;
        bit    mr;
        bit    rst;
    } ent_t;

    ent_t          sb[$];
    int            total, bad;
    logic [CW-1:0] exp_ret;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic sig_t observed();
        sig_t o;
        o.mreq = mem_req;  o.adr = AdrSrc;   o.mw  = MemWrite;   o.irw = IRWrite;
        o.pcw  = PCWrite;  o.rw  = RegWrite; o.rs  = ResultSrc;  o.a   = ALUSrcA;
        o.b    = ALUSrcB;  o.alu = ALUControl; o.imm = ImmSrc;   o.ill = illegal;
        return o;
    endfunction

    // f: IRWrite/PCWrite in FETCH, taken flag in BRANCH. ci: check ImmSrc this cycle.
    function automatic void exp_st(input string tag, input bst_e s, input bit f,
                                   input logic [3:0] alu, input logic [2:0] imm, input bit ci,
                                   input bit mr, input bit rst);
        ent_t e;
        sig_t v, m;
        v = '0;
        m = '0;
        m.mreq = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.pcw = 1'b1; m.rw = 1'b1; m.ill = 1'b1;
        if (ci) begin
            m.imm = '1;
            v.imm = imm;
        end
        case (s)
            SReset:    m.mreq = 1'b0;
            SFetch: begin
                v.mreq = 1'b1; v.irw = f; v.pcw = f; v.rs = 2'b10; v.b = 2'b10;
                m.adr = 1'b1; m.rs = '1; m.a = '1; m.b = '1; m.alu = '1;
            end
            SDecode, SAuipc: begin
                v.a = 2'b01; v.b = 2'b01; m.a = '1; m.b = '1; m.alu = '1;
            end
            SMemAdr, SJalr: begin
                v.a = 2'b10; v.b = 2'b01; m.a = '1; m.b = '1; m.alu = '1;
            end
            SMemRead: begin
                v.mreq = 1'b1; v.adr = 1'b1; m.adr = 1'b1; m.rs = '1;
            end
            SMemWb: begin
                v.rs = 2'b01; v.rw = 1'b1; m.rs = '1;
            end
            SMemWrite: begin
                v.mreq = 1'b1; v.mw = 1'b1; v.adr = 1'b1; m.adr = 1'b1;
            end
            SExecR: begin
                v.a = 2'b10; v.b = 2'b00; v.alu = alu; m.a = '1; m.b = '1; m.alu = '1;
            end
            SExecI: begin
                v.a = 2'b10; v.b = 2'b01; v.alu = alu; m.a = '1; m.b = '1; m.alu = '1;
            end
            SAluWb: begin
                v.rw = 1'b1; m.rs = '1;
            end
            SJal: begin
                v.a = 2'b01; v.b = 2'b10; v.pcw = 1'b1;
                m.a = '1; m.b = '1; m.alu = '1; m.rs = '1;
            end
            SBranch: begin
                v.a = 2'b10; v.alu = SUB; v.pcw = f;
                m.a = '1; m.b = '1; m.alu = '1; m.rs = '1;
            end
            SLui: begin
                v.a = 2'b11; v.b = 2'b01; m.a = '1; m.b = '1; m.alu = '1;
            end
            default:   v.ill = 1'b1;
        endcase
        e.tag = tag; e.v = v; e.m = m; e.mr = mr; e.rst = rst;
        sb.push_back(e);
    endfunction

    task automatic drain();
        while (sb.size() > 0) begin
            ent_t e;
            e = sb.pop_front();
            reset     = e.rst;
            mem_ready = e.mr;
            @(negedge clk);
            check(e.tag, 32'(observed() & e.m), 32'(e.v & e.m));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic retired(input string tag);
        exp_ret++;
        check(tag, 32'(instret), 32'(exp_ret));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        total = 0; bad = 0; exp_ret = '0;
        reset = 1'b1; Instr = '0; Zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        exp_st("rst0", SReset, 0, ADD, 0, 0, 1, 1);
        exp_st("rst1", SReset, 0, ADD, 0, 0, 1, 1);
        drain();
        check("rst.instret", 32'(instret), 32'(exp_ret));

        Instr = 32'h002081B3;  // add x3,x1,x2
        exp_st("add.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("add.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("add.exec", SExecR, 0, ADD, 0, 0, 1, 0);
        exp_st("add.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("add.instret");

        Instr = 32'h40208133;  // sub
        exp_st("sub.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("sub.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("sub.exec", SExecR, 0, SUB, 0, 0, 1, 0);
        exp_st("sub.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("sub.instret");

        Instr = 32'h4010D093;  // srai x1,x1,1
        exp_st("srai.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("srai.dec", SDecode, 0, ADD, 3'b000, 1, 1, 0);
        exp_st("srai.exec", SExecI, 0, SRA, 0, 0, 1, 0);
        exp_st("srai.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("srai.instret");

        Instr = 32'h40000093;  // addi x1,x0,0x400: bit 30 set but still add
        exp_st("addi.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("addi.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("addi.exec", SExecI, 0, ADD, 0, 0, 1, 0);
        exp_st("addi.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("addi.instret");

        Instr = 32'h00802283;  // lw x5,8(x0), two wait states
        exp_st("lw.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("lw.dec", SDecode, 0, ADD, 3'b000, 1, 1, 0);
        exp_st("lw.adr", SMemAdr, 0, ADD, 3'b000, 1, 1, 0);
        exp_st("lw.rd0", SMemRead, 0, ADD, 0, 0, 0, 0);
        exp_st("lw.rd1", SMemRead, 0, ADD, 0, 0, 0, 0);
        exp_st("lw.rd2", SMemRead, 0, ADD, 0, 0, 1, 0);
        exp_st("lw.wb", SMemWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("lw.instret");

        Instr = 32'h0020A423;  // sw x2,8(x1), fetch stalled once
        exp_st("sw.fetch0", SFetch, 0, ADD, 0, 0, 0, 0);
        exp_st("sw.fetch1", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("sw.dec", SDecode, 0, ADD, 3'b001, 1, 1, 0);
        exp_st("sw.adr", SMemAdr, 0, ADD, 3'b001, 1, 1, 0);
        exp_st("sw.wr0", SMemWrite, 0, ADD, 0, 0, 0, 0);
        exp_st("sw.wr1", SMemWrite, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("sw.instret");

        Instr = 32'h123450B7;  // lui
        exp_st("lui.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("lui.dec", SDecode, 0, ADD, 3'b100, 1, 1, 0);
        exp_st("lui.exec", SLui, 0, ADD, 0, 0, 1, 0);
        exp_st("lui.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("lui.instret");

        Instr = 32'h00000463;  // beq
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            exp_st("beq.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
            exp_st("beq.dec", SDecode, 0, ADD, 3'b010, 1, 1, 0);
            exp_st(z ? "beq.taken" : "beq.nottaken", SBranch, z[0], ADD, 0, 0, 1, 0);
            drain();
            retired("beq.instret");
        end

        Zero = 1'b0; lt = 1'b1; ltu = 1'b1;
        Instr = 32'h0020C463;  // blt, lt=1 -> taken
        exp_st("blt.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("blt.dec", SDecode, 0, ADD, 3'b010, 1, 1, 0);
        exp_st("blt.br", SBranch, 1, ADD, 0, 0, 1, 0);
        drain();
        retired("blt.instret");

        Instr = 32'h0020F463;  // bgeu, ltu=1 -> not taken
        exp_st("bgeu.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("bgeu.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("bgeu.br", SBranch, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("bgeu.instret");

        Instr = 32'h000100E7;  // jalr x1,0(x2)
        exp_st("jalr.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("jalr.dec", SDecode, 0, ADD, 3'b000, 1, 1, 0);
        exp_st("jalr.adr", SJalr, 0, ADD, 0, 0, 1, 0);
        exp_st("jalr.jal", SJal, 0, ADD, 0, 0, 1, 0);
        exp_st("jalr.wb", SAluWb, 0, ADD, 0, 0, 1, 0);
        drain();
        retired("jalr.instret");  // twelfth retirement, counter has wrapped

        Instr = 32'h0000007F;  // unsupported opcode
        exp_st("trap.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("trap.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) exp_st("trap.hold", STrap, 0, ADD, 0, 0, i[0], 0);
        exp_st("trap.reset", SReset, 0, ADD, 0, 0, 1, 1);
        drain();
        exp_ret = '0;
        check("trap.rst.instret", 32'(instret), 32'(exp_ret));

        Instr = 32'h00002063;  // branch with reserved funct3
        exp_st("badbr.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("badbr.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("badbr.br", SBranch, 0, ADD, 0, 0, 1, 0);
        exp_st("badbr.trap", STrap, 0, ADD, 0, 0, 1, 0);
        exp_st("badbr.reset", SReset, 0, ADD, 0, 0, 1, 1);
        drain();
        check("badbr.instret", 32'(instret), 32'(exp_ret));

        Instr = 32'h0020A423;  // sw abandoned by reset during the write stall
        exp_st("swr.fetch", SFetch, 1, ADD, 0, 0, 1, 0);
        exp_st("swr.dec", SDecode, 0, ADD, 0, 0, 1, 0);
        exp_st("swr.adr", SMemAdr, 0, ADD, 0, 0, 1, 0);
        exp_st("swr.wr0", SMemWrite, 0, ADD, 0, 0, 0, 0);
        exp_st("swr.wr1", SMemWrite, 0, ADD, 0, 0, 0, 0);
        exp_st("swr.reset", SReset, 0, ADD, 0, 0, 0, 1);
        exp_st("swr.refetch", SFetch, 0, ADD, 0, 0, 0, 0);
        drain();
        check("swr.instret", 32'(instret), 32'(exp_ret));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
